instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the accumulator CPU. It reads 16-bit instruction words from program memory through a request/acknowledge port and buffers them in a small prefetch FIFO. It splits each word into opcode, addressing-mode bit and 12-bit operand address, and hands them to the CPU over a valid/ready handshake. Taken branches and jumps reach the block as a redirect, which flushes the buffer and restarts fetch at the new PC.

## Interface
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 12'h000: first fetch address after reset
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- mem_req  out  1  memory read request
- mem_addr  out  12  read address; held stable while mem_req=1 until mem_ack
- mem_ack  in  1  read complete; mem_rdata valid in the same cycle
- mem_rdata  in  16  instruction word: [15:13] opcode, [12] AM, [11:0] address
- redirect  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc  in  12  new fetch address, valid with redirect
- out_valid  out  1  head FIFO entry available
- out_ready  in  1  CPU accepts head entry
- out_opcode  out  3  head word [15:13]
- out_am  out  1  head word [12]
- out_addr  out  12  head word [11:0]
- out_pc  out  12  address the head word was fetched from

## Operation
- State machine: FETCH, FLUSH, HALT.
  - FETCH: mem_req=1 when count<DEPTH, else mem_req=0 (stall). At most one request outstanding.
  - FLUSH: one cycle, mem_req=0 (cancels any in-flight request); then FETCH.
  - HALT: mem_req=0 until redirect.
- Memory accept: mem_req=1 and mem_ack=1 at an edge. On accept:
  - push {mem_rdata, mem_addr} into the FIFO;
  - fetch_pc increments by 1, mod 4096 (12'hFFF wraps to 12'h000);
  - if mem_rdata[15:13]=3'b111 (HALT), go to HALT. The HALT word itself is still pushed and delivered.
- Pop: out_valid=1 and out_ready=1 at an edge.
- out_valid = (count≠0). out_* are a combinational read of the head entry.
- Simultaneous push and pop: count unchanged. Push with FIFO full cannot occur, because no request is issued while full.
- Redirect has the highest priority, in any state:
  - count←0 and FIFO pointers cleared;
  - fetch_pc←redirect_pc, state←FLUSH;
  - a mem_ack in the same cycle is discarded;
  - a pop in the same cycle is consumed by the CPU, but the FIFO is cleared regardless.
- Back-to-back redirects: each restarts FLUSH; the last redirect_pc wins.
- Reset (reset=0 at an edge), including mid-request:
  - count=0, pointers 0, fetch_pc=RESET_PC, state=FETCH;
  - any in-flight ack is ignored.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_opcode=0, out_am=0, out_addr=0, out_pc=0. FIFO storage is don't-care, but outputs read as 0 while empty.
- First mem_req=1 appears in the first cycle after the edge at which reset=1 is sampled.
- mem_addr is registered and equals fetch_pc. It changes only after an accept, a redirect, or reset.
- Accept at edge N: out_valid=1 during cycle N+1 if the FIFO was empty. The next request, with incremented mem_addr, is also issued in cycle N+1.
- Zero-wait memory (mem_ack held high): one word per cycle is sustained.
- Redirect at edge N: out_valid=0 and mem_req=0 in cycle N+1 (FLUSH). mem_req=1 with mem_addr=redirect_pc in cycle N+2.
- HALT accepted at edge N: mem_req=0 from cycle N+1 on.

## Test plan
- Reset release, memory words 0x2005/0x6010/0x0000 at 0x000–0x002 with mem_ack always high, out_ready=1:
  - out_pc 0,1,2 in consecutive cycles;
  - first output: opcode=1, am=0, addr=0x005;
  - second output: am=1 (word 0x6010 decodes to opcode 3, am=0, addr 0x010 — use 0x3010 for am=1: opcode 1, am=1, addr 0x010).
- out_ready=0 with mem_ack always high:
  - exactly DEPTH=4 accepts, then mem_req=0;
  - one pop re-asserts mem_req the next cycle;
  - order preserved.
- Redirect to 0x123 while a request is pending and mem_ack arrives in the same cycle:
  - stale word not delivered;
  - out_valid=0 next cycle;
  - mem_addr=0x123 two cycles later.
- Fetch from 0xFFE, no redirect: out_pc sequence 0xFFE, 0xFFF, 0x000.
- Word 0xE000 at 0x004:
  - delivered with opcode=7;
  - mem_req stays 0 for 20 cycles;
  - redirect to 0x010 resumes fetch there.
- reset=0 for one cycle while the FIFO holds 3 entries: out_valid=0 and mem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads program memory into a DEPTH-entry prefetch FIFO and decodes the head word for the CPU.
// Latency: an accept at edge N shows as out_valid in cycle N+1 (empty FIFO); one word per cycle with zero-wait memory.
// Backpressure: out_ready=0 lets the FIFO fill, and mem_req drops while it is full; a redirect flushes everything.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_opcode,
    output logic        out_am,
    output logic [11:0] out_addr,
    output logic [11:0] out_pc
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0]    OP_HALT  = 3'b111;

    typedef enum logic [1:0] {FETCH, FLUSH, HALT} state_t;

    state_t          state, state_nxt;
    logic            run;
    logic [11:0]     fetch_pc;
    logic [27:0]     fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, accept, pop;
    logic [27:0]     head;

    assign full      = (count == FULL_CNT);
    assign accept    = mem_req & mem_ack;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign mem_addr  = fetch_pc;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            FETCH: begin
                // run holds requests off until the first cycle after reset is released
                mem_req = run & ~full;
                if (mem_req && mem_ack && mem_rdata[15:13] == OP_HALT) state_nxt = HALT;
            end
            FLUSH:   state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        if (redirect) state_nxt = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    wr_ptr   <= wr_ptr + AW'(1);
                    fetch_pc <= fetch_pc + 12'd1;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                case ({accept, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: empty entries are masked at the outputs.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= {mem_rdata, fetch_pc};
    end

    assign head       = out_valid ? fifo_mem[rd_ptr] : 28'd0;
    assign out_opcode = head[27:25];
    assign out_am     = head[24];
    assign out_addr   = head[23:12];
    assign out_pc     = head[11:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_opcode;
    logic        out_am;
    logic [11:0] out_addr;
    logic [11:0] out_pc;

    logic [15:0] mem [4096];
    assign mem_rdata = mem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_am(out_am), .out_addr(out_addr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic [11:0] rpc;
        logic        rdy;
        logic        ack;
        logic        e_req;
        logic [11:0] e_maddr;
        logic        e_vld;
        logic [2:0]  e_op;
        logic        e_am;
        logic [11:0] e_addr;
        logic [11:0] e_pc;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [11:0] maddr,
                              input logic vld, input logic [2:0] op, input logic am,
                              input logic [11:0] addr, input logic [11:0] pc);
        check({tag, ".mem_req"},    32'(mem_req),    32'(req));
        check({tag, ".mem_addr"},   32'(mem_addr),   32'(maddr));
        check({tag, ".out_valid"},  32'(out_valid),  32'(vld));
        check({tag, ".out_opcode"}, 32'(out_opcode), 32'(op));
        check({tag, ".out_am"},     32'(out_am),     32'(am));
        check({tag, ".out_addr"},   32'(out_addr),   32'(addr));
        check({tag, ".out_pc"},     32'(out_pc),     32'(pc));
    endtask

    initial begin
        int acc;
        logic ok;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h2005;
        mem[12'h001] = 16'h3010;
        mem[12'h002] = 16'h0000;
        mem[12'h003] = 16'h4111;
        mem[12'h004] = 16'hE000;
        mem[12'h005] = 16'h1234;
        mem[12'h123] = 16'h5ABC;
        for (int j = 0; j < 5; j++) mem[12'h040 + j] = 16'h1001 + 16'(j);
        mem[12'hFFE] = 16'h0AAA;
        mem[12'hFFF] = 16'h0BBB;

        //            rd  rpc     rdy  ack  req maddr   vld op   am   addr    pc
        vecs[0] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 3'd0, 1'b0, 12'h000, 12'h000};
        vecs[1] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h001, 1'b1, 3'd1, 1'b0, 12'h005, 12'h000};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h002, 1'b1, 3'd1, 1'b1, 12'h010, 12'h001};
        vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h003, 1'b1, 3'd0, 1'b0, 12'h000, 12'h002};
        // redirect while the request for 0x004 (a HALT word) is acked: it must be dropped
        vecs[4] = '{1'b1, 12'h123, 1'b1, 1'b1, 1'b1, 12'h004, 1'b1, 3'd2, 1'b0, 12'h111, 12'h003};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h123, 1'b0, 3'd0, 1'b0, 12'h000, 12'h000};
        vecs[6] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h123, 1'b0, 3'd0, 1'b0, 12'h000, 12'h000};
        vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h124, 1'b1, 3'd2, 1'b1, 12'hABC, 12'h123};

        reset = 1'b0; redirect = 1'b0; redirect_pc = 12'h000; out_ready = 1'b1; mem_ack = 1'b1;
        tick();
        tick();
        check_outs("reset", 1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 12'h000, 12'h000);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            out_ready   = vecs[i].rdy;
            mem_ack     = vecs[i].ack;
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_maddr, vecs[i].e_vld,
                       vecs[i].e_op, vecs[i].e_am, vecs[i].e_addr, vecs[i].e_pc);
            tick();
        end
        redirect = 1'b0;

        // backpressure: FIFO fills to DEPTH, then requests stop
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 12'h040;
        tick();
        redirect = 1'b0;
        check("bp.flush_req", 32'(mem_req), 32'd0);
        check("bp.flush_vld", 32'(out_valid), 32'd0);
        tick();
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_req && mem_ack) acc++;
            tick();
        end
        check("bp.accepts", 32'(acc), 32'd4);
        check("bp.stall_req", 32'(mem_req), 32'd0);
        check("bp.head_pc", 32'(out_pc), 32'h040);
        check("bp.head_addr", 32'(out_addr), 32'h001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.reassert_req", 32'(mem_req), 32'd1);
        check("bp.reassert_addr", 32'(mem_addr), 32'h044);
        check("bp.after_pop_pc", 32'(out_pc), 32'h041);
        tick();
        check("bp.refull_req", 32'(mem_req), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp.order_pc%0d", k), 32'(out_pc), 32'h041 + 32'(k));
            check($sformatf("bp.order_addr%0d", k), 32'(out_addr), 32'h002 + 32'(k));
            tick();
        end

        // PC wraps from 0xFFF to 0x000
        redirect = 1'b1; redirect_pc = 12'hFFE;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap.req", 32'(mem_req), 32'd1);
        check("wrap.maddr", 32'(mem_addr), 32'hFFE);
        tick();
        check("wrap.pc0", 32'(out_pc), 32'hFFE);
        check("wrap.addr0", 32'(out_addr), 32'hAAA);
        tick();
        check("wrap.pc1", 32'(out_pc), 32'hFFF);
        check("wrap.addr1", 32'(out_addr), 32'hBBB);
        tick();
        check("wrap.pc2", 32'(out_pc), 32'h000);
        check("wrap.op2", 32'(out_opcode), 32'd1);
        check("wrap.addr2", 32'(out_addr), 32'h005);

        // HALT word stops fetch until the next redirect
        redirect = 1'b1; redirect_pc = 12'h004;
        tick();
        redirect = 1'b0;
        tick();
        check("halt.req", 32'(mem_req), 32'd1);
        check("halt.maddr", 32'(mem_addr), 32'h004);
        tick();
        check_outs("halt.head", 1'b0, 12'h005, 1'b1, 3'd7, 1'b0, 12'h000, 12'h004);
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_req !== 1'b0) ok = 1'b0;
        end
        check("halt.req_stays_low", 32'(ok), 32'd1);
        check("halt.drained", 32'(out_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 12'h010;
        tick();
        redirect = 1'b0;
        check("halt.flush_req", 32'(mem_req), 32'd0);
        tick();
        check("halt.resume_req", 32'(mem_req), 32'd1);
        check("halt.resume_maddr", 32'(mem_addr), 32'h010);

        // reset mid-stream with 3 entries buffered and an ack in the reset cycle
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 12'h080;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        tick();
        mem_ack = 1'b0;
        check("rst3.vld", 32'(out_valid), 32'd1);
        check("rst3.maddr", 32'(mem_addr), 32'h083);
        check("rst3.head_pc", 32'(out_pc), 32'h080);
        reset = 1'b0; mem_ack = 1'b1;
        tick();
        reset = 1'b1;
        check_outs("rst3.after", 1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 12'h000, 12'h000);
        tick();
        check("rst3.first_req", 32'(mem_req), 32'd1);
        check("rst3.first_maddr", 32'(mem_addr), 32'h000);
        check("rst3.still_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
